// File: rtl/mips_maindec_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional feature macro: MAINDEC_ADDI_EN (builds the addi execute/writeback states).
module mips_maindec_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWrite,
    output logic       irWrite,
    output logic       iOrD,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       pcEn,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
`ifdef MAINDEC_ADDI_EN
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`endif
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MAINDEC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t r_state;
    logic   w_pcWrite;
    logic   w_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   if (memReady) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_RTYPEEX;
                        OP_BEQ:       r_state <= S_BEQEX;
`ifdef MAINDEC_ADDI_EN
                        OP_ADDI:      r_state <= S_ADDIEX;
`endif
                        OP_J:         r_state <= S_JEX;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (memReady) r_state <= S_MEMWB;
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWR:   if (memReady) r_state <= S_FETCH;
                S_RTYPEEX: r_state <= S_RTYPEWB;
                S_RTYPEWB: r_state <= S_FETCH;
                S_BEQEX:   r_state <= S_FETCH;
`ifdef MAINDEC_ADDI_EN
                S_ADDIEX:  r_state <= S_ADDIWB;
                S_ADDIWB:  r_state <= S_FETCH;
`endif
                S_JEX:     r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode the registered state; reset masks them so memReq drops asynchronously.
    always_comb begin
        memReq    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        iOrD      = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = '0;
        aluOp     = '0;
        pcSrc     = '0;
        illegal   = 1'b0;
        w_pcWrite = 1'b0;
        w_branch  = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    memReq    = 1'b1;
                    aluSrcB   = 2'b01;
                    irWrite   = memReady;
                    w_pcWrite = memReady;
                end
                S_DECODE: begin
                    aluSrcB = 2'b11;
                    case (op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal = 1'b0;
`ifdef MAINDEC_ADDI_EN
                        OP_ADDI: illegal = 1'b0;
`endif
                        default: illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    memReq = 1'b1;
                    iOrD   = 1'b1;
                end
                S_MEMWB: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEMWR: begin
                    memReq   = 1'b1;
                    iOrD     = 1'b1;
                    memWrite = 1'b1;
                end
                S_RTYPEEX: begin
                    aluSrcA = 1'b1;
                    aluOp   = 2'b10;
                end
                S_RTYPEWB: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                end
                S_BEQEX: begin
                    aluSrcA  = 1'b1;
                    aluOp    = 2'b01;
                    pcSrc    = 2'b01;
                    w_branch = 1'b1;
                end
`ifdef MAINDEC_ADDI_EN
                S_ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_ADDIWB: regWrite = 1'b1;
`endif
                S_JEX: begin
                    pcSrc     = 2'b10;
                    w_pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
        pcEn = w_pcWrite | (w_branch & zero);
    end

    assign state = r_state;

endmodule

// File: tb/tb_mips_maindec_fsm.sv
// Directed bench for mips_maindec_fsm; expected output bundles are hand-derived per state.
module tb_mips_maindec_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       memReady;
    logic       memReq, memWrite, irWrite, iOrD, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic       pcEn, illegal;
    logic [3:0] state;

    int n_total = 0;
    int n_pass  = 0;

    // {memReq,memWrite,irWrite,iOrD,regDst,memToReg,regWrite,aluSrcA,aluSrcB,aluOp,pcSrc,pcEn,illegal}
    logic [15:0] obs_outs;
    assign obs_outs = {memReq, memWrite, irWrite, iOrD, regDst, memToReg, regWrite, aluSrcA,
                       aluSrcB, aluOp, pcSrc, pcEn, illegal};

    localparam logic [15:0] E_RST     = 16'h0000;
    localparam logic [15:0] E_FWAIT   = 16'h8040;
    localparam logic [15:0] E_FRDY    = 16'hA042;
    localparam logic [15:0] E_DEC     = 16'h00C0;
    localparam logic [15:0] E_DECILL  = 16'h00C1;
    localparam logic [15:0] E_MEMADR  = 16'h0180;
    localparam logic [15:0] E_MEMRD   = 16'h9000;
    localparam logic [15:0] E_MEMWB   = 16'h0600;
    localparam logic [15:0] E_MEMWR   = 16'hD000;
    localparam logic [15:0] E_RTEX    = 16'h0120;
    localparam logic [15:0] E_RTWB    = 16'h0A00;
    localparam logic [15:0] E_BEQ_Z1  = 16'h0116;
    localparam logic [15:0] E_BEQ_Z0  = 16'h0114;
    localparam logic [15:0] E_JEX     = 16'h000A;
`ifdef MAINDEC_ADDI_EN
    localparam logic [15:0] E_ADDIEX  = 16'h0180;
    localparam logic [15:0] E_ADDIWB  = 16'h0200;
`endif

    mips_maindec_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .zero     (zero),
        .memReady (memReady),
        .memReq   (memReq),
        .memWrite (memWrite),
        .irWrite  (irWrite),
        .iOrD     (iOrD),
        .regDst   (regDst),
        .memToReg (memToReg),
        .regWrite (regWrite),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .aluOp    (aluOp),
        .pcSrc    (pcSrc),
        .pcEn     (pcEn),
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called just after a falling edge with inputs already set; checks, then advances one cycle.
    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] outs);
        #1;
        chk({tag, ".state"}, {12'd0, state}, {12'd0, st});
        chk({tag, ".outs"}, obs_outs, outs);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; op = 6'b000000; zero = 1'b0; memReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step("reset_hold", 4'd0, E_RST);

        // Release, start an R-type, then reset in the middle of RTYPEEX
        rst_n = 1'b1;
        step("rel_fetch_wait", 4'd0, E_FWAIT);
        memReady = 1'b1;
        step("rel_fetch_rdy", 4'd0, E_FRDY);
        memReady = 1'b0;
        step("rt0_decode", 4'd1, E_DEC);
        #1;
        chk("rt0_ex.state", {12'd0, state}, 16'd6);
        chk("rt0_ex.outs", obs_outs, E_RTEX);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.state", {12'd0, state}, 16'd0);
        chk("midrst.outs", obs_outs, E_RST);
        @(negedge clk);
        memReady = 1'b1;
        step("rst_held", 4'd0, E_RST);
        rst_n = 1'b0;
        memReady = 1'b0;
        rst_n = 1'b1;
        step("rst_release", 4'd0, E_FWAIT);

        // lw with two wait cycles in FETCH and in MEMRD: 9 cycles
        op = 6'b100011;
        step("lw_fw1", 4'd0, E_FWAIT);
        step("lw_fw2", 4'd0, E_FWAIT);
        memReady = 1'b1;
        step("lw_fr", 4'd0, E_FRDY);
        memReady = 1'b0;
        step("lw_dec", 4'd1, E_DEC);
        step("lw_adr", 4'd2, E_MEMADR);
        step("lw_rdw1", 4'd3, E_MEMRD);
        step("lw_rdw2", 4'd3, E_MEMRD);
        memReady = 1'b1;
        step("lw_rd", 4'd3, E_MEMRD);
        memReady = 1'b0;
        step("lw_wb", 4'd4, E_MEMWB);

        // sw, zero wait states
        op = 6'b101011; memReady = 1'b1;
        step("sw_f", 4'd0, E_FRDY);
        step("sw_dec", 4'd1, E_DEC);
        step("sw_adr", 4'd2, E_MEMADR);
        step("sw_wr", 4'd5, E_MEMWR);

        // sw with one wait: memWrite held through the wait
        step("sw2_f", 4'd0, E_FRDY);
        step("sw2_dec", 4'd1, E_DEC);
        step("sw2_adr", 4'd2, E_MEMADR);
        memReady = 1'b0;
        step("sw2_wrw", 4'd5, E_MEMWR);
        memReady = 1'b1;
        step("sw2_wr", 4'd5, E_MEMWR);

        // beq taken and not taken
        op = 6'b000100; zero = 1'b1;
        step("beq1_f", 4'd0, E_FRDY);
        step("beq1_dec", 4'd1, E_DEC);
        step("beq1_ex", 4'd8, E_BEQ_Z1);
        zero = 1'b0;
        step("beq0_f", 4'd0, E_FRDY);
        step("beq0_dec", 4'd1, E_DEC);
        step("beq0_ex", 4'd8, E_BEQ_Z0);

        // R-type then j
        op = 6'b000000;
        step("rt_f", 4'd0, E_FRDY);
        step("rt_dec", 4'd1, E_DEC);
        step("rt_ex", 4'd6, E_RTEX);
        step("rt_wb", 4'd7, E_RTWB);
        op = 6'b000010;
        step("j_f", 4'd0, E_FRDY);
        step("j_dec", 4'd1, E_DEC);
        step("j_ex", 4'd11, E_JEX);

        // illegal opcode: pulse then back to FETCH
        op = 6'b111111;
        step("ill_f", 4'd0, E_FRDY);
        step("ill_dec", 4'd1, E_DECILL);
        op = 6'b001000;
        step("ill_back", 4'd0, E_FRDY);

        // addi: full sequence when built, illegal otherwise
`ifdef MAINDEC_ADDI_EN
        step("addi_dec", 4'd1, E_DEC);
        step("addi_ex", 4'd9, E_ADDIEX);
        step("addi_wb", 4'd10, E_ADDIWB);
`else
        step("addi_dec", 4'd1, E_DECILL);
`endif
        memReady = 1'b0;
        step("final_fetch", 4'd0, E_FWAIT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
